stopwatch_scan_display: RTL and testbench
=========================================

# stopwatch_scan_display

Consumes the packed-BCD minute/second/10 ms outputs of the stopwatch counter core. Drives a 6-digit, time-multiplexed, common-anode seven-segment display. The block snapshots the time once per scan frame so a displayed frame is always coherent, supports a lap-hold freeze and leading-zero blanking, and renders non-BCD nibbles as a dash. It sits between the counter core and the board display pins.

## Interface
- SCAN_DIV, 50000, clk_core cycles each digit stays lit; legal range ≥1.
- clk_core  in  1  single clock, all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- min_i  in  8  minutes, packed BCD {tens,ones}.
- sec_i  in  8  seconds, packed BCD {tens,ones}.
- ms_10_i  in  8  hundredths, packed BCD {tens,ones}.
- hold  in  1  1 = suppress snapshot update (lap freeze).
- blank_lz  in  1  1 = blank minute-tens digit when it is 0.
- an_o  out  6  digit enables, active-low, one-hot-zero.
- seg_o  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp_o  out  1  decimal point, active-low.
- frame_o  out  1  one-cycle pulse when a new snapshot is taken.

## Operation
- Divider div_cnt counts 0..SCAN_DIV-1 and wraps. tick = (div_cnt==SCAN_DIV-1).
- Digit index idx counts 0..5. On tick: idx <= (idx==5) ? 0 : idx+1.
- Snapshot registers snap_min/snap_sec/snap_ms (8 b each). On tick with idx==5 and hold==0, they load min_i/sec_i/ms_10_i. In the same cycle, frame_o is registered to 1. Otherwise frame_o is 0.
- While hold==1, the snapshot is unchanged and frame_o stays 0. The scan keeps running.
- Digit map, with nibble as source:
  - idx0 = snap_ms[3:0], an_o[0]
  - idx1 = snap_ms[7:4], an_o[1]
  - idx2 = snap_sec[3:0], an_o[2], dp lit
  - idx3 = snap_sec[7:4], an_o[3]
  - idx4 = snap_min[3:0], an_o[4], dp lit
  - idx5 = snap_min[7:4], an_o[5]
- Segment codes, active-low gfedcba:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - nibble 0xA–0xF = 0111111 (dash, g only)
- Blanking: idx5 with blank_lz==1 and nibble==0 gives seg_o=1111111 and dp_o=1. an_o[5] is still driven 0.
- Outputs an_o/seg_o/dp_o are registered. They reflect idx and snap as of the previous cycle, i.e. one cycle latency.
- No state machine beyond the divider/index counters. No back-pressure; inputs are sampled only at snapshot.

## Timing
- Reset values (cycle after rst sampled high):
  - div_cnt=0, idx=0, snap_*=8'h00.
  - an_o=6'b111111, seg_o=7'b1111111, dp_o=1, frame_o=0.
- rst has priority over everything. Asserting it mid-frame aborts the scan and clears the snapshot. No partial state is retained.
- First cycle after rst deasserts: outputs are still at reset values (registered latency).
- From the second cycle after rst deasserts: an_o=6'b111110, seg_o=1000000.
- Frame length is 6·SCAN_DIV cycles.
- The first snapshot is taken on the tick ending idx5 of the first frame. frame_o is high the following cycle.
- Newly captured digits appear on outputs starting with idx0 of the next frame.
- With SCAN_DIV=1, tick is asserted every cycle and idx advances every cycle. The behaviour is otherwise identical.
- Input changes between snapshots are never visible. Changes coincident with a snapshot tick are captured.
- hold rising in the snapshot cycle blocks that capture. hold falling takes effect at the next frame boundary.

## Test plan
- Reset: SCAN_DIV=4; rst=1 for 3 cycles.
  - During reset: an_o=3F, seg_o=7F, dp_o=1, frame_o=0.
  - 2nd cycle after release: an_o=111110, seg_o=1000000.
- Normal scan: min=12, sec=34, ms=56, run 3 frames.
  - frame_o pulses every 24 cycles.
  - Second frame shows idx0..5 = 6,5,4(dp_o=0),3,2(dp_o=0),1.
  - idx2 seg_o=0011001.
- Hold: after display shows 12:34.56, set hold=1 and change inputs to 59:59.99 for 2 frames.
  - Display unchanged; no frame_o.
  - Release hold: 59:59.99 appears from idx0 of the frame after the next boundary.
- Blanking: min=05.
  - blank_lz=1: idx5 seg_o=1111111, an_o=011111.
  - blank_lz=0: idx5 seg_o=1000000.
- Invalid BCD: ms=A3 → idx1 seg_o=0111111, idx0 seg_o=0110000.
- Mid-frame reset: assert rst during idx3 of a captured frame.
  - Next cycle: reset values.
  - After release: all digits show 0 until the next snapshot.

Source files
------------

// File: rtl/stopwatch_scan_display.sv
// Six-digit multiplexed seven-segment driver for the stopwatch core.
// Snapshots the BCD time once per scan frame, with lap-hold, zero blanking and dash rendering.
module stopwatch_scan_display #(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic       clk_core,
  input  logic       rst,
  input  logic [7:0] min_i,
  input  logic [7:0] sec_i,
  input  logic [7:0] ms_10_i,
  input  logic       hold,
  input  logic       blank_lz,
  output logic [5:0] an_o,
  output logic [6:0] seg_o,
  output logic       dp_o,
  output logic       frame_o
);

  localparam int unsigned DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [DW-1:0] div_cnt;
  logic [2:0]    idx;
  logic [7:0]    snap_min, snap_sec, snap_ms;
  logic          tick;
  logic          capture;
  logic [3:0]    nibble;
  logic [5:0]    an_next;
  logic [6:0]    seg_next;
  logic          dp_next;

  assign tick    = (div_cnt == DW'(SCAN_DIV - 1));
  assign capture = tick && (idx == 3'd5) && !hold;

  always_ff @(posedge clk_core) begin
    if (rst) begin
      div_cnt  <= '0;
      idx      <= '0;
      snap_min <= '0;
      snap_sec <= '0;
      snap_ms  <= '0;
      an_o     <= '1;
      seg_o    <= '1;
      dp_o     <= 1'b1;
      frame_o  <= 1'b0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      if (tick) idx <= (idx == 3'd5) ? '0 : idx + 3'd1;
      frame_o <= capture;
      if (capture) begin
        snap_min <= min_i;
        snap_sec <= sec_i;
        snap_ms  <= ms_10_i;
      end
      an_o  <= an_next;
      seg_o <= seg_next;
      dp_o  <= dp_next;
    end
  end

  always_comb begin
    nibble  = snap_ms[3:0];
    an_next = '1;
    dp_next = 1'b1;
    case (idx)
      3'd0: begin nibble = snap_ms[3:0];  an_next = 6'b111110; end
      3'd1: begin nibble = snap_ms[7:4];  an_next = 6'b111101; end
      3'd2: begin nibble = snap_sec[3:0]; an_next = 6'b111011; dp_next = 1'b0; end
      3'd3: begin nibble = snap_sec[7:4]; an_next = 6'b110111; end
      3'd4: begin nibble = snap_min[3:0]; an_next = 6'b101111; dp_next = 1'b0; end
      3'd5: begin nibble = snap_min[7:4]; an_next = 6'b011111; end
      default: begin nibble = 4'd0; an_next = '1; end
    endcase

    case (nibble)
      4'd0:    seg_next = 7'b1000000;
      4'd1:    seg_next = 7'b1111001;
      4'd2:    seg_next = 7'b0100100;
      4'd3:    seg_next = 7'b0110000;
      4'd4:    seg_next = 7'b0011001;
      4'd5:    seg_next = 7'b0010010;
      4'd6:    seg_next = 7'b0000010;
      4'd7:    seg_next = 7'b1111000;
      4'd8:    seg_next = 7'b0000000;
      4'd9:    seg_next = 7'b0010000;
      default: seg_next = 7'b0111111;
    endcase

    // Blanked minute-tens keeps its anode enabled so the scan duty stays uniform.
    if ((idx == 3'd5) && blank_lz && (nibble == 4'd0)) begin
      seg_next = '1;
      dp_next  = 1'b1;
    end
  end

endmodule

// File: tb/tb_stopwatch_scan_display.sv
// Bench for stopwatch_scan_display: cycle-count reference model feeding a scoreboard,
// plus directed frame walks for scan order, hold, blanking, dash and mid-frame reset.
module tb_stopwatch_scan_display;

  localparam int unsigned D = 4;

  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                         S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010,
                         S6 = 7'b0000010, S7 = 7'b1111000, S8 = 7'b0000000,
                         S9 = 7'b0010000, DASH = 7'b0111111, BLANK = 7'b1111111;
  localparam logic [6:0] SEG_TBL [10] = '{S0, S1, S2, S3, S4, S5, S6, S7, S8, S9};
  localparam logic [14:0] RST_WORD = {6'h3F, 7'h7F, 1'b1, 1'b0};

  logic       clk_core = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] min_i = '0, sec_i = '0, ms_10_i = '0;
  logic       hold = 1'b0, blank_lz = 1'b0;
  logic [5:0] an_o;
  logic [6:0] seg_o;
  logic       dp_o, frame_o;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  logic [14:0] sb [$];
  int unsigned cyc;
  logic [23:0] msnap;

  stopwatch_scan_display #(.SCAN_DIV(D)) dut (
    .clk_core (clk_core),
    .rst      (rst),
    .min_i    (min_i),
    .sec_i    (sec_i),
    .ms_10_i  (ms_10_i),
    .hold     (hold),
    .blank_lz (blank_lz),
    .an_o     (an_o),
    .seg_o    (seg_o),
    .dp_o     (dp_o),
    .frame_o  (frame_o)
  );

  always #5 clk_core = ~clk_core;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: position in the scan derived purely from edges since reset.
  function automatic logic [14:0] model_out(input int unsigned k, input logic [23:0] s,
                                            input logic hb, input logic bz);
    int unsigned d;
    logic [3:0]  n;
    logic [5:0]  a;
    logic [6:0]  sg;
    logic        dp, fr;
    d  = (k / D) % 6;
    n  = s[d*4 +: 4];
    a  = ~(6'b000001 << d);
    sg = (n > 4'd9) ? DASH : SEG_TBL[n];
    dp = !((d == 2) || (d == 4));
    if ((d == 5) && bz && (n == 4'd0)) begin
      sg = BLANK;
      dp = 1'b1;
    end
    fr = ((k % D) == D - 1) && (d == 5) && !hb;
    return {a, sg, dp, fr};
  endfunction

  always @(posedge clk_core) begin
    if (rst) begin
      sb.push_back(RST_WORD);
      cyc   <= 0;
      msnap <= '0;
    end else begin
      sb.push_back(model_out(cyc, msnap, hold, blank_lz));
      cyc <= cyc + 1;
      if (((cyc % D) == D - 1) && (((cyc / D) % 6) == 5) && !hold)
        msnap <= {min_i, sec_i, ms_10_i};
    end
  end

  always @(negedge clk_core) begin
    if (sb.size() > 0) begin
      automatic logic [14:0] e = sb.pop_front();
      check("sb_an",    an_o,    e[14:9]);
      check("sb_seg",   seg_o,   e[8:2]);
      check("sb_dp",    dp_o,    e[1]);
      check("sb_frame", frame_o, e[0]);
    end
  end

  function automatic logic [41:0] pack6(input logic [6:0] d0, d1, d2, d3, d4, d5);
    return {d5, d4, d3, d2, d1, d0};
  endfunction

  // Called at the negedge where idx0 of a frame is on the outputs; leaves at the next idx0.
  task automatic check_frame(input string tag, input logic [41:0] segs);
    logic [5:0] ea;
    logic       edp;
    for (int d = 0; d < 6; d++) begin
      ea  = ~(6'b000001 << d);
      edp = !((d == 2) || (d == 4));
      if (d == 5 && segs[41:35] == BLANK) edp = 1'b1;
      check($sformatf("%s_d%0d_an", tag, d), an_o, ea);
      check($sformatf("%s_d%0d_seg", tag, d), seg_o, segs[d*7 +: 7]);
      check($sformatf("%s_d%0d_dp", tag, d), dp_o, edp);
      repeat (D) @(negedge clk_core);
    end
  endtask

  task automatic wait_frame(input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_core);
      if (frame_o) begin
        seen = 1'b1;
        break;
      end
    end
    check({tag, "_frame_seen"}, seen, 1'b1);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int unsigned period;

    repeat (3) begin
      @(negedge clk_core);
      check("rst_an", an_o, 6'h3F);
      check("rst_seg", seg_o, 7'h7F);
      check("rst_dp", dp_o, 1'b1);
      check("rst_frame", frame_o, 1'b0);
    end
    rst     = 1'b0;
    min_i   = 8'h12;
    sec_i   = 8'h34;
    ms_10_i = 8'h56;
    @(negedge clk_core);
    check("post_rst_an", an_o, 6'b111110);
    check("post_rst_seg", seg_o, S0);

    wait_frame("first");
    period = 0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk_core);
      period = i;
      if (frame_o) break;
    end
    check("frame_period", period, 6 * D);
    @(negedge clk_core);
    check_frame("run", pack6(S6, S5, S4, S3, S2, S1));

    hold    = 1'b1;
    min_i   = 8'h59;
    sec_i   = 8'h59;
    ms_10_i = 8'h99;
    check_frame("hold_a", pack6(S6, S5, S4, S3, S2, S1));
    check_frame("hold_b", pack6(S6, S5, S4, S3, S2, S1));
    hold = 1'b0;
    wait_frame("release");
    @(negedge clk_core);
    check_frame("released", pack6(S9, S9, S9, S5, S9, S5));

    min_i    = 8'h05;
    blank_lz = 1'b1;
    wait_frame("blank");
    @(negedge clk_core);
    check_frame("blank_on", pack6(S9, S9, S9, S5, S5, BLANK));
    blank_lz = 1'b0;
    check_frame("blank_off", pack6(S9, S9, S9, S5, S5, S0));

    ms_10_i = 8'hA3;
    wait_frame("dash");
    @(negedge clk_core);
    check_frame("dash", pack6(S3, DASH, S9, S5, S5, S0));

    repeat (3 * D) @(negedge clk_core);
    check("mid_an_idx3", an_o, 6'b110111);
    rst = 1'b1;
    @(negedge clk_core);
    check("mid_rst_an", an_o, 6'h3F);
    check("mid_rst_seg", seg_o, 7'h7F);
    check("mid_rst_dp", dp_o, 1'b1);
    check("mid_rst_frame", frame_o, 1'b0);
    rst = 1'b0;
    @(negedge clk_core);
    check_frame("after_rst", pack6(S0, S0, S0, S0, S0, S0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
